// File: rtl/matmul_systolic_param.sv
// ---------------------------------------------------------------------------
// matmul_systolic_param
//
// Output-stationary SIZE x SIZE systolic matrix multiplier. One operation
// computes C (+)= A(SIZE x K) * B(K x SIZE). The block reads one A column and
// one B row per cycle from two external synchronous-read memories, skews the
// lanes into the PE array, lets the wavefront settle, then drains C one row
// per ready/valid beat.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high
//   start               begins an operation when sampled high in IDLE
//   accumulate          sampled with start: 1 keeps prior C, 0 clears C
//   final_mat_mul_size  inner dimension K (0 or > SIZE means SIZE)
//   a_addr / b_addr     operand memory read addresses (0 outside FEED)
//   a_data / b_data     operand memory read data, lane i at [i*DWIDTH +: DWIDTH]
//                       a_data lane i at address k = A[i][k]
//                       b_data lane j at address k = B[k][j]
//   c_data              one C row, column j at [j*2*DWIDTH +: 2*DWIDTH]
//   c_valid / c_ready   row handshake
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse at the end of an operation
// ---------------------------------------------------------------------------
module matmul_systolic_param #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7,
  parameter int SIZE   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       accumulate,
  input  logic [7:0]                 final_mat_mul_size,
  output logic [AWIDTH-1:0]          a_addr,
  output logic [AWIDTH-1:0]          b_addr,
  input  logic [SIZE*DWIDTH-1:0]     a_data,
  input  logic [SIZE*DWIDTH-1:0]     b_data,
  output logic [SIZE*2*DWIDTH-1:0]   c_data,
  output logic                       c_valid,
  input  logic                       c_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = 2 * DWIDTH;
  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [7:0]    k_reg, k_next;
  logic [RW-1:0] row_reg, row_next;
  logic [7:0]    k_eff;
  logic          start_op;
  logic          clear_acc;
  logic          mac_en;
  logic          feed_d_reg;

  // Out-of-range K (including 0) runs a full SIZE-deep product.
  assign k_eff = (final_mat_mul_size != 8'd0 && final_mat_mul_size <= 8'(SIZE))
               ? final_mat_mul_size : 8'(SIZE);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      k_reg      <= '0;
      row_reg    <= '0;
      feed_d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      k_reg      <= k_next;
      row_reg    <= row_next;
      // Memory read latency is one cycle: data for a FEED address shows up
      // on a_data/b_data the cycle after it was driven.
      feed_d_reg <= (state_reg == S_FEED);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_next     = k_reg;
    row_next   = row_reg;
    start_op   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_op   = 1'b1;
          k_next     = k_eff;
          cnt_next   = '0;
          state_next = S_FEED;
        end
      end
      S_FEED: begin
        if (cnt_reg == k_reg - 8'd1) begin
          cnt_next   = '0;
          state_next = S_FLUSH;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_FLUSH: begin
        // 2*SIZE cycles covers the read latency, the deepest skew stage and
        // the diagonal travel to PE(SIZE-1,SIZE-1).
        if (cnt_reg == 8'(2 * SIZE - 1)) begin
          cnt_next   = '0;
          row_next   = '0;
          state_next = S_DRAIN;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_DRAIN: begin
        if (c_ready) begin
          if (row_reg == RW'(SIZE - 1)) begin
            state_next = S_DONE;
          end else begin
            row_next = row_reg + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign c_valid   = (state_reg == S_DRAIN);
  assign a_addr    = (state_reg == S_FEED) ? AWIDTH'(cnt_reg) : '0;
  assign b_addr    = (state_reg == S_FEED) ? AWIDTH'(cnt_reg) : '0;
  assign clear_acc = start_op & ~accumulate;
  assign mac_en    = (state_reg == S_FEED) || (state_reg == S_FLUSH);

  // -------------------------------------------------------------------------
  // Input skew: lane i passes through i+1 registers so that A[i][k] and
  // B[k][j] meet in PE(i,j) on the same cycle. Zero is injected whenever the
  // memory is not returning FEED data.
  // -------------------------------------------------------------------------
  logic signed [DWIDTH-1:0] a_edge [SIZE];
  logic signed [DWIDTH-1:0] b_edge [SIZE];

  genvar gi, gj;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_skew
      logic signed [DWIDTH-1:0] a_sr [gi+1];
      logic signed [DWIDTH-1:0] b_sr [gi+1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d <= gi; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= feed_d_reg ? a_data[gi*DWIDTH +: DWIDTH] : '0;
          b_sr[0] <= feed_d_reg ? b_data[gi*DWIDTH +: DWIDTH] : '0;
          for (int d = 1; d <= gi; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end

      assign a_edge[gi] = a_sr[gi];
      assign b_edge[gi] = b_sr[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // PE array: A flows right, B flows down, each PE accumulates in place.
  // -------------------------------------------------------------------------
  logic signed [DWIDTH-1:0] a_fwd [SIZE][SIZE];
  logic signed [DWIDTH-1:0] b_fwd [SIZE][SIZE];
  logic signed [PW-1:0]     acc   [SIZE][SIZE];

  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_row
      for (gj = 0; gj < SIZE; gj++) begin : g_col
        logic signed [DWIDTH-1:0] a_in;
        logic signed [DWIDTH-1:0] b_in;
        logic signed [PW-1:0]     prod;

        if (gj == 0) begin : g_a_edge
          assign a_in = a_edge[gi];
        end else begin : g_a_fwd
          assign a_in = a_fwd[gi][gj-1];
        end

        if (gi == 0) begin : g_b_edge
          assign b_in = b_edge[gj];
        end else begin : g_b_fwd
          assign b_in = b_fwd[gi-1][gj];
        end

        // Signed full-width product; the sum wraps modulo 2^PW.
        assign prod = PW'(a_in) * PW'(b_in);

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            a_fwd[gi][gj] <= '0;
            b_fwd[gi][gj] <= '0;
            acc[gi][gj]   <= '0;
          end else begin
            a_fwd[gi][gj] <= a_in;
            b_fwd[gi][gj] <= b_in;
            if (clear_acc) begin
              acc[gi][gj] <= '0;
            end else if (mac_en) begin
              acc[gi][gj] <= acc[gi][gj] + prod;
            end
          end
        end
      end
    end
  endgenerate

  // Accumulators are frozen outside FEED/FLUSH, so the selected row is
  // stable for as long as the consumer stalls.
  always_comb begin
    c_data = '0;
    for (int j = 0; j < SIZE; j++) begin
      c_data[j*PW +: PW] = acc[row_reg][j];
    end
  end

endmodule

// File: tb/tb_matmul_systolic_param.sv
// ---------------------------------------------------------------------------
// tb_matmul_systolic_param
//
// Directed bench for matmul_systolic_param (SIZE=4, DWIDTH=16). Operand
// memories are modelled with a one-cycle registered read. Stimulus is driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_matmul_systolic_param;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int SZ = 4;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              accumulate;
  logic [7:0]        final_mat_mul_size;
  logic [AW-1:0]     a_addr;
  logic [AW-1:0]     b_addr;
  logic [SZ*DW-1:0]  a_data = '0;
  logic [SZ*DW-1:0]  b_data = '0;
  logic [SZ*PW-1:0]  c_data;
  logic              c_valid;
  logic              c_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [SZ*DW-1:0] mem_a [128];
  logic [SZ*DW-1:0] mem_b [128];

  // Results of the latest run_op
  logic [SZ*PW-1:0] rows [SZ];
  int  beats;
  int  done_cnt;
  int  done_gap;
  int  stall_seen;
  bit  stall_bad;
  bit  timeout;
  int  addr_log [8];

  matmul_systolic_param #(.DWIDTH(DW), .AWIDTH(AW), .SIZE(SZ)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .accumulate         (accumulate),
    .final_mat_mul_size (final_mat_mul_size),
    .a_addr             (a_addr),
    .b_addr             (b_addr),
    .a_data             (a_data),
    .b_data             (b_data),
    .c_data             (c_data),
    .c_valid            (c_valid),
    .c_ready            (c_ready),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= mem_a[a_addr];
    b_data <= mem_b[b_addr];
  end

  task automatic clear_mem();
    for (int k = 0; k < 128; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
  endtask

  task automatic fill_all(input int k, input logic [DW-1:0] va, input logic [DW-1:0] vb);
    for (int l = 0; l < SZ; l++) begin
      mem_a[k][l*DW +: DW] = va;
      mem_b[k][l*DW +: DW] = vb;
    end
  endtask

  task automatic set_identity_b();
    clear_mem();
    for (int i = 0; i < SZ; i++) begin
      for (int k = 0; k < SZ; k++) begin
        mem_a[k][i*DW +: DW] = (i == k) ? 16'd1 : 16'd0;
        mem_b[k][i*DW +: DW] = 16'(k * 4 + i);
      end
    end
  endtask

  // Runs one operation; c_ready is dropped for stall_n cycles while the
  // row with index stall_row is presented.
  task automatic run_op(input int ksz, input bit acc, input int stall_row, input int stall_n);
    int cyc;
    int last_hs;
    int stalled;
    bit fin;
    logic [SZ*PW-1:0] held;
    beats = 0; done_cnt = 0; done_gap = -1; stall_bad = 0; timeout = 0;
    stalled = 0; last_hs = -100; fin = 0; cyc = 0; held = '0;
    for (int i = 0; i < SZ; i++) rows[i] = '0;
    @(negedge clk);
    start = 1'b1;
    accumulate = acc;
    final_mat_mul_size = 8'(ksz);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      if (cyc < 8) addr_log[cyc] = int'(a_addr);
      if (c_valid) begin
        if (beats == stall_row && stalled < stall_n) begin
          c_ready = 1'b0;
          if (stalled == 0) held = c_data;
          else if (c_data !== held) stall_bad = 1;
          stalled++;
        end else begin
          c_ready = 1'b1;
          if (stalled > 0 && beats == stall_row && c_data !== held) stall_bad = 1;
          if (beats < SZ) rows[beats] = c_data;
          beats++;
          last_hs = cyc;
        end
      end else begin
        c_ready = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_gap = cyc - last_hs;
      end
      if (done_cnt > 0 && cyc >= last_hs + 4) fin = 1;
      cyc++;
      @(negedge clk);
    end
    c_ready = 1'b1;
    stall_seen = stalled;
    if (!fin) timeout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; accumulate = 1'b0; c_ready = 1'b1;
    final_mat_mul_size = 8'd4;
    clear_mem();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b expected 0", c_valid); end
    checks++; if (a_addr !== 7'd0 || b_addr !== 7'd0) begin errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", a_addr, b_addr); end
    checks++; if (c_data !== '0) begin errors++; $display("FAIL reset_c_data: got %h expected 0", c_data); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_identity();
    logic [SZ*PW-1:0] exp_row;
    set_identity_b();
    run_op(4, 1'b0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ident_timeout: got %b expected 0", timeout); end
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) exp_row[j*PW +: PW] = 32'(i * 4 + j);
      checks++; if (rows[i] !== exp_row) begin errors++; $display("FAIL ident_row%0d: got %h expected %h", i, rows[i], exp_row); end
    end
    checks++; if (beats !== 4) begin errors++; $display("FAIL ident_beats: got %0d expected 4", beats); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ident_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_gap !== 1) begin errors++; $display("FAIL ident_done_latency: got %0d expected 1", done_gap); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (addr_log[c] !== ((c < 4) ? c : 0)) begin errors++; $display("FAIL ident_addr%0d: got %0d expected %0d", c, addr_log[c], (c < 4) ? c : 0); end
    end
    $display("test_identity done");
  endtask

  task automatic test_k_sizes();
    int exp_k2 [SZ][SZ];
    logic [SZ*PW-1:0] exp_row;
    exp_k2 = '{'{21, 22, 23, 24}, '{22, 24, 26, 28}, '{23, 26, 29, 32}, '{24, 28, 32, 36}};
    clear_mem();
    fill_all(2, 16'h7FFF, 16'h7FFF);
    fill_all(3, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < SZ; i++) begin
      mem_a[0][i*DW +: DW] = 16'(i + 1);
      mem_a[1][i*DW +: DW] = 16'd2;
      mem_b[0][i*DW +: DW] = 16'(i + 1);
      mem_b[1][i*DW +: DW] = 16'd10;
    end
    run_op(2, 1'b0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL k2_timeout: got %b expected 0", timeout); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (addr_log[c] !== ((c < 2) ? c : 0)) begin errors++; $display("FAIL k2_addr%0d: got %0d expected %0d", c, addr_log[c], (c < 2) ? c : 0); end
    end
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) exp_row[j*PW +: PW] = 32'(exp_k2[i][j]);
      checks++; if (rows[i] !== exp_row) begin errors++; $display("FAIL k2_row%0d: got %h expected %h", i, rows[i], exp_row); end
    end
    // K=0 and K=9 both run the full depth, picking up 2*0x7FFF^2 = 0x7FFE0002.
    run_op(0, 1'b0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL k0_timeout: got %b expected 0", timeout); end
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) exp_row[j*PW +: PW] = 32'h7FFE0002 + 32'(exp_k2[i][j]);
      checks++; if (rows[i] !== exp_row) begin errors++; $display("FAIL k0_row%0d: got %h expected %h", i, rows[i], exp_row); end
    end
    run_op(9, 1'b0, -1, 0);
    for (int j = 0; j < SZ; j++) exp_row[j*PW +: PW] = 32'h7FFE0002 + 32'(exp_k2[3][j]);
    checks++; if (rows[3] !== exp_row) begin errors++; $display("FAIL k9_row3: got %h expected %h", rows[3], exp_row); end
    $display("test_k_sizes done");
  endtask

  task automatic test_accumulate();
    logic [SZ*PW-1:0] exp4;
    logic [SZ*PW-1:0] exp8;
    exp4 = {4{32'd4}};
    exp8 = {4{32'd8}};
    clear_mem();
    for (int k = 0; k < SZ; k++) fill_all(k, 16'd1, 16'd1);
    run_op(4, 1'b0, -1, 0);
    for (int i = 0; i < SZ; i++) begin
      checks++; if (rows[i] !== exp4) begin errors++; $display("FAIL acc_first_row%0d: got %h expected %h", i, rows[i], exp4); end
    end
    run_op(4, 1'b1, -1, 0);
    for (int i = 0; i < SZ; i++) begin
      checks++; if (rows[i] !== exp8) begin errors++; $display("FAIL acc_add_row%0d: got %h expected %h", i, rows[i], exp8); end
    end
    run_op(4, 1'b0, -1, 0);
    for (int i = 0; i < SZ; i++) begin
      checks++; if (rows[i] !== exp4) begin errors++; $display("FAIL acc_clear_row%0d: got %h expected %h", i, rows[i], exp4); end
    end
    $display("test_accumulate done");
  endtask

  task automatic test_backpressure();
    logic [SZ*PW-1:0] exp_row;
    set_identity_b();
    run_op(4, 1'b0, 1, 5);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b expected 0", timeout); end
    checks++; if (stall_seen !== 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_seen); end
    checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL bp_stable: c_data changed during stall, flag %b expected 0", stall_bad); end
    checks++; if (beats !== 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", beats); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) exp_row[j*PW +: PW] = 32'(i * 4 + j);
      checks++; if (rows[i] !== exp_row) begin errors++; $display("FAIL bp_row%0d: got %h expected %h", i, rows[i], exp_row); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_signed_wrap();
    logic [SZ*PW-1:0] exp_neg;
    exp_neg = {4{32'hFFFFFFFE}};
    clear_mem();
    fill_all(0, 16'hFFFF, 16'h0002);
    run_op(1, 1'b0, -1, 0);
    for (int i = 0; i < SZ; i++) begin
      checks++; if (rows[i] !== exp_neg) begin errors++; $display("FAIL signed_row%0d: got %h expected %h", i, rows[i], exp_neg); end
    end
    for (int k = 0; k < SZ; k++) fill_all(k, 16'h8000, 16'h8000);
    run_op(4, 1'b0, -1, 0);
    for (int i = 0; i < SZ; i++) begin
      checks++; if (rows[i] !== '0) begin errors++; $display("FAIL wrap_row%0d: got %h expected 0", i, rows[i]); end
    end
    $display("test_signed_wrap done");
  endtask

  task automatic test_reset_mid();
    int dcount;
    bit found;
    logic [SZ*PW-1:0] exp4;
    exp4 = {4{32'd4}};
    clear_mem();
    for (int k = 0; k < SZ; k++) fill_all(k, 16'd1, 16'd1);
    // Abort during FEED
    @(negedge clk);
    start = 1'b1; accumulate = 1'b0; final_mat_mul_size = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || c_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_feed_outputs: got busy %b valid %b done %b expected 0 0 0", busy, c_valid, done); end
    checks++; if (a_addr !== 7'd0 || b_addr !== 7'd0) begin errors++; $display("FAIL rst_feed_addr: got %h/%h expected 0/0", a_addr, b_addr); end
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL rst_feed_quiet: got %0d busy/done cycles expected 0", dcount); end
    // Abort during DRAIN
    start = 1'b1; accumulate = 1'b0;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (c_valid) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_drain_reach: got %b expected 1", found); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || c_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_drain_outputs: got busy %b valid %b done %b expected 0 0 0", busy, c_valid, done); end
    checks++; if (c_data !== '0) begin errors++; $display("FAIL rst_drain_c_data: got %h expected 0", c_data); end
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL rst_drain_no_done: got %0d expected 0", dcount); end
    // accumulate=1 after reset must start from zero
    run_op(4, 1'b1, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_clean_timeout: got %b expected 0", timeout); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rst_clean_done: got %0d expected 1", done_cnt); end
    for (int i = 0; i < SZ; i++) begin
      checks++; if (rows[i] !== exp4) begin errors++; $display("FAIL rst_clean_row%0d: got %h expected %h", i, rows[i], exp4); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_k_sizes();
    test_accumulate();
    test_backpressure();
    test_signed_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_systolic_param.md
MATMUL_SYSTOLIC_PARAM -- requirements
Module: matmul_systolic_param

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter AWIDTH, default 7, operand memory address width.
REQ-003 SHALL have parameter SIZE, default 4, PE array dimension (SIZE x SIZE); legal range 2..8.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, starts one operation when sampled high in IDLE.
REQ-007 SHALL have port accumulate, input, 1, sampled with start; 1 = keep prior C, 0 = clear C.
REQ-008 SHALL have port final_mat_mul_size, input, 8, inner dimension K.
REQ-009 SHALL have port a_addr / b_addr, output, AWIDTH each, operand memory read addresses.
REQ-010 SHALL have port a_data / b_data, input, SIZE*DWIDTH each; lane i at bits [i*DWIDTH +: DWIDTH].
REQ-011 SHALL have port c_data, output, SIZE*2*DWIDTH, one C row per beat; column j at [j*2*DWIDTH +: 2*DWIDTH].
REQ-012 SHALL have port c_valid, output, 1, c_data holds a valid row.
REQ-013 SHALL have port c_ready, input, 1, consumer accepts the row.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at end of operation.

Function
REQ-016 SHALL implement FSM IDLE -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
REQ-017 SHALL compute effective K as final_mat_mul_size when it is 1..SIZE, and as SIZE otherwise (including 0).
REQ-018 On start in IDLE SHALL latch accumulate and K, enter FEED, and zero all accumulators that same edge if accumulate=0.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 FEED SHALL last K cycles, driving a_addr = b_addr = cycle index 0..K-1; both SHALL hold 0 outside FEED.
REQ-021 SHALL register memory data with 1-cycle read latency: data for address n is valid on the cycle after n is driven.
REQ-022 SHALL feed A row lane i delayed by i cycles and B column lane j delayed by j cycles (skew), with zero injected in all non-data cycles.
REQ-023 PE(i,j) SHALL compute acc <= acc + a*b, forward a right and b down with 1-cycle register each.
REQ-024 Operands SHALL be signed two's complement; the product SHALL be 2*DWIDTH bits; the accumulator SHALL be 2*DWIDTH bits and wrap modulo 2^(2*DWIDTH) without saturation.
REQ-025 FLUSH SHALL last exactly 2*SIZE cycles, after which every PE holds its final sum.
REQ-026 DRAIN SHALL present row 0 first, then rows 1..SIZE-1, with c_valid high throughout.
REQ-027 DRAIN SHALL advance to the next row only on a cycle where c_valid and c_ready are both high.
REQ-028 c_data SHALL hold stable while c_valid=1 and c_ready=0.
REQ-029 Accumulators SHALL NOT change during DRAIN.
REQ-030 After the row SIZE-1 handshake, the FSM SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-031 c_valid SHALL be 0 outside DRAIN.
REQ-032 Accumulators SHALL retain their values in IDLE so that a following accumulate=1 operation adds to them.

Reset
REQ-033 While reset is high, SHALL force FSM=IDLE, all accumulators, skew and forwarding registers = 0, a_addr = b_addr = 0, and c_valid = busy = done = 0.
REQ-034 Reset asserted mid-operation SHALL abort immediately with no done pulse; the next start SHALL behave as after power-up.

Verification
REQ-035 SHALL verify: SIZE=4, K=4, A=identity, B[i][j]=i*4+j, accumulate=0 -> drained rows equal B; done 1 cycle after the 4th handshake.
REQ-036 SHALL verify: K=2 with lanes 2..3 of memory holding 0x7FFF -> C equals 4x2 by 2x4 product; lanes beyond K have no effect; K=0 behaves as K=4.
REQ-037 SHALL verify: two operations, all operands 1, K=4, second with accumulate=1 -> every C element = 8; a third with accumulate=0 -> 4.
REQ-038 SHALL verify: c_ready held low 5 cycles during row 1 -> c_data stable and unchanged, exactly 4 beats accepted, no row skipped or duplicated.
REQ-039 SHALL verify: signed and wrap behaviour, a=-1 (0xFFFF), b=2, K=1 -> C = 0xFFFFFFFE; 0x8000*0x8000 accumulated over 4 terms -> wraps to 0x00000000.
REQ-040 SHALL verify: reset pulsed during FEED and again during DRAIN -> outputs zero at once, no done pulse, and a clean subsequent operation gives correct results.
